alu_issue_ctrl: RTL and testbench



---
 rtl/alu_issue_ctrl.sv | 126 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/decode sequencer for the 16-bit ALU: accepts one instruction at a time,
// reads operands from an 8x16 register file, drives the ALU and writes the result back.
module alu_issue_ctrl #(
  parameter int REG_COUNT = 8,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [1:0]        ALU_func,
  output logic [DATA_W-1:0] ALU_srcdata_1,
  output logic [DATA_W-1:0] ALU_srcdata_2,
  input  logic [DATA_W-1:0] ALU_result,
  output logic              wb_valid,
  output logic [2:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              illegal_op,
  output logic              busy,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  state_t            state_q, state_d;
  logic [15:0]       instr_q, instr_d;
  logic [1:0]        func_q, func_d;
  logic [DATA_W-1:0] src1_q, src1_d;
  logic [DATA_W-1:0] src2_q, src2_d;
  logic [2:0]        wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [DATA_W-1:0] regs_q [REG_COUNT];
  logic [DATA_W-1:0] regs_d [REG_COUNT];

  logic [2:0] opc, rd, rs1, rs2;
  logic       op_alu, op_ldi, op_illegal;

  assign opc        = instr_q[15:13];
  assign rd         = instr_q[12:10];
  assign rs1        = instr_q[9:7];
  assign rs2        = instr_q[6:4];
  assign op_alu     = ~opc[2];
  assign op_ldi     = (opc == 3'b100);
  assign op_illegal = opc[2] & (|opc[1:0]);

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    func_d    = func_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    regs_d    = regs_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        // r0 is never written, so reading regs_q[0] already yields zero
        if (op_alu) begin
          func_d  = opc[1:0];
          src1_d  = regs_q[rs1];
          src2_d  = regs_q[rs2];
          state_d = EXEC;
        end else if (op_ldi) begin
          wb_addr_d = rd;
          wb_data_d = {{(DATA_W-8){1'b0}}, instr_q[7:0]};
          state_d   = WB;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        wb_addr_d = rd;
        wb_data_d = ALU_result;
        state_d   = WB;
      end
      WB: begin
        if (wb_addr_q != 3'd0) regs_d[wb_addr_q] = wb_data_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      func_q    <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      func_q    <= func_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      regs_q    <= regs_d;
    end
  end

  // Pulses are masked while rst is high so an aborted instruction never signals.
  assign wb_valid      = (state_q == WB) & ~rst;
  assign illegal_op    = (state_q == DECODE) & op_illegal & ~rst;
  assign instr_ready   = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign ALU_func      = func_q;
  assign ALU_srcdata_1 = src1_q;
  assign ALU_srcdata_2 = src2_q;
  assign wb_addr       = wb_addr_q;
  assign wb_data       = wb_data_q;
  assign dbg_data      = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed and random instructions against a register-level reference model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [1:0]  ALU_func;
  logic [15:0] ALU_srcdata_1;
  logic [15:0] ALU_srcdata_2;
  logic [15:0] ALU_result;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        illegal_op;
  logic        busy;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  logic [15:0] mregs [8];
  int n_assert = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .ALU_func(ALU_func), .ALU_srcdata_1(ALU_srcdata_1), .ALU_srcdata_2(ALU_srcdata_2),
    .ALU_result(ALU_result),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .illegal_op(illegal_op), .busy(busy),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Combinational ALU the controller drives.
  logic [31:0] mul_full;
  assign mul_full = {16'b0, ALU_srcdata_1} * {16'b0, ALU_srcdata_2};
  always_comb begin
    ALU_result = 16'h0;
    case (ALU_func)
      2'd0: ALU_result = ALU_srcdata_1 + ALU_srcdata_2;
      2'd1: ALU_result = ALU_srcdata_1 - ALU_srcdata_2;
      2'd2: ALU_result = mul_full[15:0];
      2'd3: ALU_result = {15'b0, (ALU_srcdata_1 < ALU_srcdata_2)};
      default: ALU_result = 16'h0;
    endcase
  end

  function automatic logic [15:0] ref_res(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [7:0] imm);
    longint la, lb, r;
    la = longint'(a);
    lb = longint'(b);
    case (op)
      3'd0:    r = (la + lb) % 65536;
      3'd1:    r = (la - lb + 65536) % 65536;
      3'd2:    r = (la * lb) % 65536;
      3'd3:    r = (la < lb) ? 1 : 0;
      3'd4:    r = longint'(imm);
      default: r = 0;
    endcase
    return 16'(r);
  endfunction

  function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int rs2);
    return {3'(op), 3'(rd), 3'(rs1), 3'(rs2), 4'h0};
  endfunction

  function automatic logic [15:0] enc_ldi(input int rd, input int imm);
    return {3'b100, 3'(rd), 2'b00, 8'(imm)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk(tag, dbg_data, mregs[i]);
    end
  endtask

  // Issues one instruction and checks every cycle until the controller is ready again.
  task automatic run_op(input logic [15:0] ins, input bit hold);
    logic [2:0]  op, rd, rs1, rs2;
    logic [15:0] a, b, res;
    int lat, cnt;
    op  = ins[15:13];
    rd  = ins[12:10];
    rs1 = ins[9:7];
    rs2 = ins[6:4];
    a   = mregs[rs1];
    b   = mregs[rs2];
    res = ref_res(op, a, b, ins[7:0]);
    lat = (op < 3'd4) ? 3 : (op == 3'd4) ? 2 : 1;
    instr = ins;
    instr_valid = 1'b1;
    cnt = 0;
    while (instr_ready !== 1'b1 && cnt < 20) begin
      step();
      cnt++;
    end
    chk("accept_ready", instr_ready, 1);
    chk("accept_no_wb", wb_valid, 0);
    for (int c = 1; c <= lat; c++) begin
      step();
      instr_valid = hold;
      instr = 16'($urandom);
      chk("busy", busy, 1);
      chk("ready_low", instr_ready, 0);
      chk("wb_valid", wb_valid, (c == lat && op < 3'd5));
      chk("illegal_op", illegal_op, (c == 1 && op > 3'd4));
      if (op < 3'd4 && c >= 2) begin
        chk("alu_func", ALU_func, op[1:0]);
        chk("alu_src1", ALU_srcdata_1, a);
        chk("alu_src2", ALU_srcdata_2, b);
      end
      if (c == lat && op < 3'd5) begin
        chk("wb_addr", wb_addr, rd);
        chk("wb_data", wb_data, res);
      end
    end
    step();
    chk("ready_again", instr_ready, 1);
    chk("wb_done", wb_valid, 0);
    chk("illegal_done", illegal_op, 0);
    if (op < 3'd5 && rd != 3'd0) mregs[rd] = res;
    if (!hold) begin
      instr_valid = 1'b0;
      dbg_addr = rd;
      #1;
      chk("dbg_rd", dbg_data, mregs[rd]);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 16'h0;
    dbg_addr = 3'd0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_illegal", illegal_op, 0);
    chk("rst_func", ALU_func, 0);
    chk("rst_src1", ALU_srcdata_1, 0);
    chk("rst_src2", ALU_srcdata_2, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    chk_regs("rst_regs");

    // Directed arithmetic, wraparound and compare cases
    run_op(enc_ldi(1, 8'h34), 0);
    run_op(enc_ldi(2, 8'h12), 0);
    run_op(enc(0, 3, 1, 2), 0);
    chk("add_r3", mregs[3], 16'h0046);
    run_op(enc(1, 4, 1, 2), 0);
    run_op(enc(1, 4, 2, 1), 0);
    chk("sub_wrap_r4", mregs[4], 16'hFFDE);
    run_op(enc_ldi(1, 8'hFF), 0);
    run_op(enc_ldi(2, 8'hFF), 0);
    run_op(enc(2, 5, 1, 2), 0);
    chk("mul_r5", mregs[5], 16'hFE01);
    run_op(enc(2, 5, 5, 5), 0);
    run_op(enc_ldi(1, 8'h03), 0);
    run_op(enc_ldi(2, 8'h05), 0);
    run_op(enc(3, 6, 1, 2), 0);
    run_op(enc(3, 7, 2, 1), 0);
    run_op(enc(3, 7, 4, 1), 0);
    run_op(16'hE000, 0);
    run_op(16'hA123, 0);
    run_op(16'hDFFF, 0);
    run_op(enc(0, 0, 3, 4), 0);
    run_op(enc_ldi(0, 8'h77), 0);
    chk_regs("directed_regs");

    // Back-to-back stream with instr_valid held high and junk on instr while busy
    for (int k = 0; k < 10; k++)
      run_op(enc($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7)), 1);
    instr_valid = 1'b0;
    chk_regs("stream_regs");

    // Random mix of all opcodes
    for (int k = 0; k < 40; k++) begin
      int op;
      op = $urandom_range(0, 7);
      if (op == 4) run_op(enc_ldi($urandom_range(0, 7), $urandom_range(0, 255)), 0);
      else run_op({3'(op), 13'($urandom)}, 0);
    end
    chk_regs("random_regs");

    // Reset while an ADD is in EXEC
    instr = enc(0, 3, 5, 6);
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    chk("exec_busy", busy, 1);
    rst = 1'b1;
    step();
    chk("rst_abort_wb0", wb_valid, 0);
    chk("rst_abort_ill0", illegal_op, 0);
    step();
    chk("rst_abort_wb1", wb_valid, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
    chk("post_rst_ready", instr_ready, 1);
    chk("post_rst_wb_valid", wb_valid, 0);
    chk("post_rst_func", ALU_func, 0);
    chk("post_rst_src1", ALU_srcdata_1, 0);
    chk("post_rst_src2", ALU_srcdata_2, 0);
    chk("post_rst_wb_addr", wb_addr, 0);
    chk("post_rst_wb_data", wb_data, 0);
    chk_regs("post_rst_regs");
    run_op(enc_ldi(2, 8'h9A), 0);
    run_op(enc(0, 1, 2, 2), 0);
    chk_regs("final_regs");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
